// File: rtl/pnu_serial_tx_if.sv
// Parallel producer handshake for pnu_serial_tx: a word plus a valid/ready pair.
// The producer drives the master modport; the transmitter takes the slave modport.
interface pnu_serial_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             tx_valid;
  logic             tx_ready;

  modport master (
    output data_in,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  data_in,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/pnu_serial_tx.sv
// Framed parallel-to-serial transmitter: start(0), WIDTH data bits LSB first, stop(1).
// Define PNU_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module pnu_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  pnu_serial_tx_if.slave   bus,
  output logic             tx_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef PNU_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             clk_term;
`ifdef PNU_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign clk_term     = (clk_cnt_q == CLK_LAST);
  assign tx_out       = tx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign bus.tx_ready = ready_q;

  // The line value for the next cycle is decided here and registered, so tx_out
  // changes on the same edge that moves the FSM into a new bit period.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // (an unassigned path in always_comb would infer a latch).
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef PNU_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    if (state_q != IDLE) begin
      clk_cnt_d = clk_term ? '0 : clk_cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_valid && ready_q) begin
          state_d   = START;
          shift_d   = bus.data_in;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
`ifdef PNU_TX_PARITY_EN
          parity_d  = ^bus.data_in;
`endif
        end
      end

      START: begin
        if (clk_term) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end

      DATA: begin
        if (clk_term) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef PNU_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_d[0];
          end
        end
      end

`ifdef PNU_TX_PARITY_EN
      PARITY: begin
        if (clk_term) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      STOP: begin
        if (clk_term) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Reset is asynchronous so a mid-frame abort returns the line high at once.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PNU_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef PNU_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: doc/pnu_serial_tx.md
Name: pnu_serial_tx

Overview:
- Parallel-in, serial-out framed transmitter: drives a single-wire serial line from a parallel data word.
- Counterpart to the team's enable-gated capture registers and serial receivers: it produces the bit stream those capture on the receive end.
- Frame format: start bit (0), WIDTH data bits LSB first, optional parity bit, stop bit (1). Every bit is held for CLKS_PER_BIT clocks.
- Sits between a parallel producer (valid/ready handshake) and the board-level serial pin.

Parameters:
- WIDTH, 8: data bits per frame; legal range 1..32.
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range >= 1. CLKS_PER_BIT = 1 is legal.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  WIDTH  word to transmit; sampled only on the accept edge.
- tx_valid  input  1  producer has a word available.
- tx_ready  output  1  block can accept a word; registered.
- tx_out  output  1  serial line; registered; idles at 1.
- busy  output  1  frame in progress; registered.
- done  output  1  one-cycle pulse marking the end of a frame; registered.

Behaviour:
- Reset (reset = 0, asynchronous): tx_out = 1, tx_ready = 1, busy = 0, done = 0, state = IDLE, bit counter = 0, clock counter = 0, shift register = 0. Reset takes effect immediately, including mid-frame: the line returns to 1 with no stop bit.
- FSM states: IDLE, START, DATA, PARITY (present only with the optional feature), STOP.
- Accept: tx_valid = 1 and tx_ready = 1 at a rising edge (edge k). On that edge:
  - data_in is latched into the shift register;
  - state goes to START; tx_out = 0, tx_ready = 0, busy = 1.
- While busy, tx_valid is ignored. Changes on data_in have no effect after the accept edge.
- Each state holds for CLKS_PER_BIT cycles, counted by a clock counter that runs 0..CLKS_PER_BIT-1. The state advances when the counter reaches terminal count.
- START -> DATA.
- DATA: tx_out = bit 0 of the shift register. The register shifts right once per bit. After WIDTH bits, DATA -> STOP (or PARITY when the optional feature is enabled).
- STOP: tx_out = 1. At terminal count:
  - state goes to IDLE; tx_ready = 1, busy = 0;
  - done = 1 for exactly one cycle.
- Timing without parity:
  - start bit occupies cycles k+1 .. k+C (C = CLKS_PER_BIT);
  - data bit i occupies cycles k+1+(i+1)C .. k+(i+2)C;
  - stop bit ends at edge k+(WIDTH+2)C, which sets done = 1 and tx_ready = 1.
- Back-to-back frames: if tx_valid is held at 1, the next accept occurs at edge k+(WIDTH+2)C+1. This leaves exactly one idle-high cycle between frames, so accept spacing is (WIDTH+2)C+1 cycles.
- tx_ready and busy are always complementary.
- done never coincides with an accept edge.
- Counter widths: clock counter is $clog2(CLKS_PER_BIT) bits, minimum 1; bit counter is $clog2(WIDTH+1) bits. No counter may wrap inside a state.

Optional Feature:
- Macro: PNU_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx_out = XOR of the latched word (even parity), held for C cycles. Frame length becomes (WIDTH+3)C; done is asserted at edge k+(WIDTH+3)C.
- Undefined: no PARITY state, no parity logic; frame length is (WIDTH+2)C.

Test Plan:
1. Reset held at 0 for 3 cycles, then released, tx_valid = 0 -> tx_out = 1, tx_ready = 1, busy = 0, done = 0 for 20 cycles.
2. WIDTH = 8, C = 4, data_in = 0xA5, tx_valid pulsed for 1 cycle -> tx_out = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; done pulses at accept + 40; tx_ready = 0 throughout the frame.
3. tx_valid held at 1, data_in = 0x3C then 0xFF -> accepts spaced exactly 41 cycles apart; one idle-high cycle between the two stop/start bits; the second frame carries 0xFF.
4. Reset driven to 0 at accept + 17 (mid-DATA) -> tx_out = 1, tx_ready = 1, busy = 0 asynchronously, no done pulse; a new frame 0x01 afterwards transmits correctly.
5. C = 1, WIDTH = 8, data_in = 0x80 -> 10-cycle frame: bits 0,0,0,0,0,0,0,0,1,1 (start, seven 0s, MSB 1, stop); done at accept + 10.
6. PNU_TX_PARITY_EN defined, data_in = 0x07, C = 4 -> parity bit = 1 for 4 cycles before the stop bit; done at accept + 44.
